// File: rtl/v2f_lsu_pkg.sv
// Shared types and lane helpers for the v2f load/store unit.
// Byte-select and load-extension functions live here so the FSM and aligner agree.
package v2f_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_RESP
  } lsu_state_t;

  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] bs;
    case (size)
      SZ_B:    bs = 4'b0001 << off;
      SZ_H:    bs = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    bs = 4'b1111;
      default: bs = 4'b0000;
    endcase
    return bs;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                         input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = data[{off, 3'b000} +: 8];
    h = data[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/v2f_lsu_align.sv
// Combinational lane logic: byte selects, replicated store data, extended load data.
module v2f_lsu_align
  import v2f_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_select,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  always_comb begin
    byte_select = byte_sel(size, off);
    rdata_ext   = extend(rdata, size, off, uns);
    case (size)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/v2f_mem_lsu.sv
// Load/store initiator between the core memory stage and the byte-selectable RAM.
// state       | meaning
// ST_IDLE     | ready for a request, decodes and error-checks on handshake
// ST_RD_ISSUE | RD_EN pulse to the RAM
// ST_RD_WAIT  | RAM read data valid, extend and register it
// ST_WR_ISSUE | WR_EN pulse with byte selects and replicated data
// ST_RESP     | response held until RESP_READY
module v2f_mem_lsu
  import v2f_lsu_pkg::*;
#(
  parameter int          SIZE      = 4,
  parameter int          ABITS     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_UNSIGNED,
  input  logic [31:0]      REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [31:0]      RESP_RDATA,
  output logic             RESP_ERR,
  output logic             RD_EN,
  output logic [ABITS-1:0] RD_ADDR,
  input  logic [31:0]      RD_DATA,
  output logic             WR_EN,
  output logic [ABITS-1:0] WR_ADDR,
  output logic [31:0]      WR_DATA,
  output logic [3:0]       BYTE_SELECT
);

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  lsu_state_t       state, state_nxt;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;
  logic [ABITS-1:0] word_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0]      off_in;
  logic [29:0]      word_in;
  logic             req_err;
  logic             handshake;
  logic [3:0]       bsel;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;

  assign off_in    = REQ_ADDR - BASE_ADDR;
  assign word_in   = off_in[31:2];
  assign handshake = (state == ST_IDLE) && REQ_VALID;

  always_comb begin
    req_err = 1'b0;
    if (REQ_SIZE == 2'd3)                            req_err = 1'b1;
    if (REQ_SIZE == SZ_H && off_in[0])               req_err = 1'b1;
    if (REQ_SIZE == SZ_W && off_in[1:0] != 2'b00)    req_err = 1'b1;
    if (REQ_ADDR < BASE_ADDR)                        req_err = 1'b1;
    if ({2'b00, word_in} >= SIZE_W)                  req_err = 1'b1;
  end

  v2f_lsu_align u_align (
    .size        (size_q),
    .off         (off_q),
    .uns         (uns_q),
    .wdata       (wdata_q),
    .rdata       (RD_DATA),
    .byte_select (bsel),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge CLK) begin
    if (ARST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (handshake) begin
        size_q  <= REQ_SIZE;
        uns_q   <= REQ_UNSIGNED;
        off_q   <= off_in[1:0];
        word_q  <= word_in[ABITS-1:0];
        wdata_q <= REQ_WDATA;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state == ST_RD_WAIT) rdata_q <= rdata_ext;
      if (state == ST_RESP && RESP_READY) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (req_err)     state_nxt = ST_RESP;
          else if (REQ_WE) state_nxt = ST_WR_ISSUE;
          else             state_nxt = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = ST_RESP;
      ST_WR_ISSUE: state_nxt = ST_RESP;
      ST_RESP:     if (RESP_READY) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // RAM strobes are masked by ARST so a reset edge never commits a write.
  always_comb begin
    REQ_READY   = 1'b0;
    RESP_VALID  = 1'b0;
    RD_EN       = 1'b0;
    RD_ADDR     = '0;
    WR_EN       = 1'b0;
    WR_ADDR     = '0;
    WR_DATA     = '0;
    BYTE_SELECT = '0;
    case (state)
      ST_IDLE: REQ_READY = 1'b1;
      ST_RD_ISSUE: begin
        if (!ARST) begin
          RD_EN   = 1'b1;
          RD_ADDR = word_q;
        end
      end
      ST_WR_ISSUE: begin
        if (!ARST) begin
          WR_EN       = 1'b1;
          WR_ADDR     = word_q;
          WR_DATA     = wdata_rep;
          BYTE_SELECT = bsel;
        end
      end
      ST_RESP: RESP_VALID = 1'b1;
      default: ;
    endcase
  end

  assign RESP_RDATA = rdata_q;
  assign RESP_ERR   = err_q;

endmodule

// File: doc/v2f_mem_lsu.md
Name: v2f_mem_lsu

Overview:
- Load/store initiator that drives the read and write ports of the blackbox programmable RAM on behalf of a CPU core.
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Converts each request into a word-addressed RAM access: generates byte selects and lane-replicated write data, and extracts/extends sub-word load data.
- Sits between the core's memory stage and the 32-bit, byte-selectable, 1-cycle-registered-read RAM.

Parameters:
- SIZE, 4, number of 32-bit words in the attached RAM.
- ABITS, 2, RAM word-address width; SIZE must be <= 2**ABITS.
- BASE_ADDR, 0, byte address mapped to RAM word 0; must be word-aligned.

Ports:
- CLK  in  1  clock, rising edge.
- ARST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  LSU can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RESP_VALID  out  1  response present.
- RESP_READY  in  1  core accepts the response.
- RESP_RDATA  out  32  extended load data; 0 for stores and errors.
- RESP_ERR  out  1  misaligned, illegal size, or out-of-range access.
- RD_EN  out  1  to RAM RD_EN.
- RD_ADDR  out  ABITS  to RAM RD_ADDR.
- RD_DATA  in  32  from RAM; valid on the cycle after RD_EN is sampled.
- WR_EN  out  1  to RAM WR_EN.
- WR_ADDR  out  ABITS  to RAM WR_ADDR.
- WR_DATA  out  32  to RAM WR_DATA.
- BYTE_SELECT  out  4  to RAM BYTE_SELECT.

Behaviour:
- Reset (ARST high at a clock edge): state IDLE. All outputs 0 except REQ_READY = 1. All captured request registers cleared. A request or response in flight is discarded.
- RAM read and write clocks both tie to CLK. RAM write path is unaffected by LSU reset; RAM program reload is a separate signal.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE:
  - REQ_READY = 1. A handshake occurs when REQ_VALID & REQ_READY.
  - On handshake, capture all REQ_* fields. Compute off = REQ_ADDR - BASE_ADDR and word = off[31:2].
  - Error checks, in order:
    - size == 3;
    - half with off[0] != 0;
    - word with off[1:0] != 0;
    - REQ_ADDR < BASE_ADDR;
    - word >= SIZE.
  - Any error -> RESP with RESP_ERR = 1 and no RAM access.
  - Otherwise: store -> WR_ISSUE; load -> RD_ISSUE.
- RD_ISSUE: RD_EN = 1, RD_ADDR = word[ABITS-1:0] for exactly one cycle -> RD_WAIT.
- RD_WAIT: sample RD_DATA. Select lane by off[1:0]:
  - byte: data[8*off+:8];
  - half: data[16*off[1]+:16];
  - word: full 32 bits.
  - Extend per REQ_UNSIGNED. Register the result into RESP_RDATA -> RESP.
- WR_ISSUE: WR_EN = 1 for exactly one cycle, with:
  - WR_ADDR = word;
  - BYTE_SELECT: byte = 1 << off[1:0], half = off[1] ? 4'b1100 : 4'b0011, word = 4'b1111;
  - WR_DATA: byte = wdata[7:0] replicated 4x, half = wdata[15:0] replicated 2x, word = wdata.
  - Next state RESP with RESP_RDATA = 0, RESP_ERR = 0.
- RESP:
  - RESP_VALID = 1 and RESP_RDATA/RESP_ERR held stable until RESP_READY is sampled high.
  - Then return to IDLE and clear RESP_VALID.
  - No back-to-back overlap: REQ_READY = 0 in every state except IDLE.
- Latency, acceptance edge to RESP_VALID high:
  - load: 3 cycles;
  - store: 2 cycles;
  - error: 1 cycle.
  - With RESP_READY held high, throughput is one load per 4 cycles and one store per 3 cycles.
- RAM strobes:
  - RD_EN, WR_EN, and BYTE_SELECT are 0 outside their ISSUE states.
  - RD_ADDR, WR_ADDR, and WR_DATA are 0 outside their ISSUE states.
- Address arithmetic is 32-bit unsigned. BASE_ADDR + 4*SIZE wrapping past 2**32 is unsupported.
- ARST asserted in any state overrides the transition; a pending WR_EN is not issued on that edge.

Decomposition:
- Package v2f_lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum;
  - functions byte_sel(size, off) and extend(data, size, off, unsigned).
- Sub-module v2f_lsu_align: purely combinational; produces BYTE_SELECT, replicated WR_DATA, and extended load data. Shared by the FSM and by the bench's reference model.

Test Plan:
- Store word 0xDEADBEEF at BASE_ADDR+4, then LW from the same address -> WR_EN one cycle with WR_ADDR=1 and BYTE_SELECT=1111; load response 0xDEADBEEF with RESP_VALID 3 cycles after acceptance.
- SB 0x80 at offset 6, then LB and LBU at offset 6 -> BYTE_SELECT=0100 and WR_DATA=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x1234 at offset 2 over word 0xAABBCCDD -> BYTE_SELECT=1100; LW returns 0x1234CCDD.
- LH at offset 1, SW at offset 2, size=3, and word >= SIZE -> RESP_ERR=1 after 1 cycle; RD_EN and WR_EN never asserted.
- Hold RESP_READY=0 for 5 cycles after a load -> RESP_VALID and RESP_RDATA stable; REQ_READY=0 throughout; a new request is accepted only after the release.
- Assert ARST during RD_WAIT and during WR_ISSUE -> next cycle in IDLE with REQ_READY=1 and all other outputs 0; no RESP_VALID pulse.
